// File: rtl/matmul_sequencer_if.sv
// Command, operand-read and result-write signals of the matmul sequencer.
// The slave side belongs to the sequencer; the master side to host and memories.
interface matmul_sequencer_if #(
   parameter int DIM_W  = 8,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40
);
   logic                     start;
   logic [DIM_W-1:0]         m;
   logic [DIM_W-1:0]         k;
   logic [DIM_W-1:0]         n;
   logic [ADDR_W-1:0]        a_base;
   logic [ADDR_W-1:0]        b_base;
   logic [ADDR_W-1:0]        c_base;
   logic                     rd_en;
   logic [ADDR_W-1:0]        a_addr;
   logic [ADDR_W-1:0]        b_addr;
   logic signed [DATA_W-1:0] a_data;
   logic signed [DATA_W-1:0] b_data;
   logic                     c_we;
   logic [ADDR_W-1:0]        c_addr;
   logic signed [ACC_W-1:0]  c_data;
   logic                     busy;
   logic                     done;

   modport master (
      output start, m, k, n, a_base, b_base, c_base, a_data, b_data,
      input  rd_en, a_addr, b_addr, c_we, c_addr, c_data, busy, done
   );

   modport slave (
      input  start, m, k, n, a_base, b_base, c_base, a_data, b_data,
      output rd_en, a_addr, b_addr, c_we, c_addr, c_data, busy, done
   );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequences a MAC datapath over row-major A (m x k) and B (k x n) to produce C = A x B.
// Addresses are walked incrementally; one C element costs k fetch + drain + write cycles.
module matmul_sequencer #(
   parameter int DIM_W  = 8,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40
) (
   input  logic              clock,
   input  logic              reset,
   matmul_sequencer_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

   function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [DATA_W-1:0] a,
                                                          input logic signed [DATA_W-1:0] b);
      logic signed [2*DATA_W-1:0] p;
      p = a * b;
      return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
   endfunction

   state_t                   state_q, state_d;
   logic [DIM_W-1:0]         m_q, m_d, k_q, k_d, n_q, n_d;
   logic [DIM_W-1:0]         i_q, i_d, l_q, l_d, j_q, j_d;
   logic [ADDR_W-1:0]        a_row_q, a_row_d, b_col_q, b_col_d, b_base_q, b_base_d;
   logic [ADDR_W-1:0]        c_ptr_q, c_ptr_d;
   logic                     rd_en_q, rd_en_d, first_q, first_d;
   logic [ADDR_W-1:0]        a_addr_q, a_addr_d, b_addr_q, b_addr_d;
   logic                     vld_p1_q, vld_p1_d, first_p1_q, first_p1_d;
   logic signed [ACC_W-1:0]  prod_p1, acc_p1_q, acc_d;
   logic                     c_we_q, c_we_d;
   logic [ADDR_W-1:0]        c_addr_q, c_addr_d;
   logic signed [ACC_W-1:0]  c_data_q, c_data_d;
   logic                     busy_q, busy_d, done_q, done_d;

   always_comb begin
      state_d  = state_q;
      m_d      = m_q;      k_d = k_q;      n_d = n_q;
      i_d      = i_q;      l_d = l_q;      j_d = j_q;
      a_row_d  = a_row_q;  b_col_d = b_col_q;  b_base_d = b_base_q;
      c_ptr_d  = c_ptr_q;
      rd_en_d  = 1'b0;     first_d = 1'b0;
      a_addr_d = '0;       b_addr_d = '0;
      c_we_d   = 1'b0;     c_addr_d = '0;   c_data_d = '0;
      busy_d   = busy_q;   done_d = 1'b0;

      // p1: operand data arrives one cycle after its rd_en; first pair loads the accumulator
      vld_p1_d   = rd_en_q;
      first_p1_d = first_q;
      prod_p1    = sext_prod(bus.a_data, bus.b_data);
      acc_d      = acc_p1_q;
      if (vld_p1_q)
         acc_d = first_p1_q ? prod_p1 : acc_p1_q + prod_p1;

      unique case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               m_d = bus.m;  k_d = bus.k;  n_d = bus.n;
               i_d = '0;     l_d = '0;     j_d = '0;
               a_row_d  = bus.a_base;
               b_col_d  = bus.b_base;
               b_base_d = bus.b_base;
               c_ptr_d  = bus.c_base;
               busy_d   = 1'b1;
               if (bus.m == '0 || bus.k == '0 || bus.n == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = S_FETCH;
                  rd_en_d  = 1'b1;
                  first_d  = 1'b1;
                  a_addr_d = bus.a_base;
                  b_addr_d = bus.b_base;
               end
            end
         end
         S_FETCH: begin
            if (j_q == k_q - DIM_W'(1)) begin
               state_d = S_DRAIN;
            end else begin
               j_d      = j_q + DIM_W'(1);
               rd_en_d  = 1'b1;
               a_addr_d = a_addr_q + ADDR_W'(1);
               b_addr_d = b_addr_q + ADDR_W'(n_q);
            end
         end
         S_DRAIN: begin
            state_d  = S_WRITE;
            c_we_d   = 1'b1;
            c_addr_d = c_ptr_q;
            c_data_d = acc_d;
         end
         S_WRITE: begin
            c_ptr_d = c_ptr_q + ADDR_W'(1);
            j_d     = '0;
            if (i_q == m_q - DIM_W'(1) && l_q == n_q - DIM_W'(1)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               if (l_q == n_q - DIM_W'(1)) begin
                  l_d     = '0;
                  i_d     = i_q + DIM_W'(1);
                  a_row_d = a_row_q + ADDR_W'(k_q);
                  b_col_d = b_base_q;
               end else begin
                  l_d     = l_q + DIM_W'(1);
                  b_col_d = b_col_q + ADDR_W'(1);
               end
               state_d  = S_FETCH;
               rd_en_d  = 1'b1;
               first_d  = 1'b1;
               a_addr_d = a_row_d;
               b_addr_d = b_col_d;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      acc_p1_q <= acc_d;
      if (reset) begin
         state_q  <= S_IDLE;
         m_q <= '0;  k_q <= '0;  n_q <= '0;
         i_q <= '0;  l_q <= '0;  j_q <= '0;
         a_row_q  <= '0;  b_col_q <= '0;  b_base_q <= '0;  c_ptr_q <= '0;
         rd_en_q  <= 1'b0;  first_q <= 1'b0;
         a_addr_q <= '0;    b_addr_q <= '0;
         vld_p1_q <= 1'b0;  first_p1_q <= 1'b0;
         c_we_q   <= 1'b0;  c_addr_q <= '0;  c_data_q <= '0;
         busy_q   <= 1'b0;  done_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q <= m_d;  k_q <= k_d;  n_q <= n_d;
         i_q <= i_d;  l_q <= l_d;  j_q <= j_d;
         a_row_q  <= a_row_d;  b_col_q <= b_col_d;  b_base_q <= b_base_d;  c_ptr_q <= c_ptr_d;
         rd_en_q  <= rd_en_d;  first_q <= first_d;
         a_addr_q <= a_addr_d; b_addr_q <= b_addr_d;
         vld_p1_q <= vld_p1_d; first_p1_q <= first_p1_d;
         c_we_q   <= c_we_d;   c_addr_q <= c_addr_d;  c_data_q <= c_data_d;
         busy_q   <= busy_d;   done_q <= done_d;
      end
   end

   assign bus.rd_en  = rd_en_q;
   assign bus.a_addr = a_addr_q;
   assign bus.b_addr = b_addr_q;
   assign bus.c_we   = c_we_q;
   assign bus.c_addr = c_addr_q;
   assign bus.c_data = c_data_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: operand RAM models plus per-scenario tasks with
// hand-computed results, write cycles and addresses.
module tb_matmul_sequencer;
   localparam int DIM_W = 8, ADDR_W = 16, DATA_W = 16, ACC_W = 40;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   matmul_sequencer_if #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();
   matmul_sequencer #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clock(clock), .reset(reset), .bus(bus)
   );

   logic signed [15:0] amem [0:65535];
   logic signed [15:0] bmem [0:65535];

   always @(posedge clock)
      if (bus.rd_en) begin
         bus.a_data <= amem[bus.a_addr];
         bus.b_data <= bmem[bus.b_addr];
      end

   int checks = 0;
   int errors = 0;

   logic [15:0] wa [$];
   logic [39:0] wd [$];
   int          wc [$];
   logic [15:0] ra [$];
   int          rd_cnt, done_rel, busy1, busy_after;
   logic [31:0] rd_bits;
   logic [91:0] snap;
   logic        timed_out;

   function automatic logic [91:0] out_vec();
      return {bus.rd_en, bus.a_addr, bus.b_addr, bus.c_we, bus.c_addr, bus.c_data, bus.busy, bus.done};
   endfunction

   task automatic run_cmd(input logic [7:0] mm, input logic [7:0] kk, input logic [7:0] nn,
                          input logic [15:0] ab, input logic [15:0] bb, input logic [15:0] cb,
                          input int pulse_at, input int reset_at, input int budget);
      int rel;
      wa.delete(); wd.delete(); wc.delete(); ra.delete();
      rd_cnt = 0; done_rel = -1; busy1 = -1; busy_after = -1; rd_bits = '0; snap = '1;
      @(negedge clock);
      bus.start = 1'b1; bus.m = mm; bus.k = kk; bus.n = nn;
      bus.a_base = ab; bus.b_base = bb; bus.c_base = cb;
      rel = 0;
      while (1) begin
         @(negedge clock);
         rel++;
         if (bus.rd_en) begin
            rd_cnt++;
            ra.push_back(bus.a_addr);
            if (rel <= 32) rd_bits[rel-1] = 1'b1;
         end
         if (bus.c_we) begin
            wa.push_back(bus.c_addr); wd.push_back(bus.c_data); wc.push_back(rel);
         end
         if (bus.done && done_rel < 0) done_rel = rel;
         if (rel == 1) busy1 = int'(bus.busy);
         if (rel == reset_at + 1) snap = out_vec();
         if (done_rel >= 0 && rel == done_rel + 1) begin
            busy_after = int'(bus.busy);
            break;
         end
         if (rel >= budget) break;
         bus.start = (rel == pulse_at);
         if (rel == pulse_at) begin
            bus.m = 8'd1; bus.k = 8'd3; bus.n = 8'd1;
            bus.a_base = 16'h0777; bus.b_base = 16'h0888; bus.c_base = 16'h0999;
         end
         reset = (rel == reset_at);
      end
      bus.start = 1'b0;
      reset = 1'b0;
      timed_out = (done_rel < 0);
   endtask

   task automatic load_2x2();
      amem[16'h000] = 16'sd1; amem[16'h001] = 16'sd2; amem[16'h002] = 16'sd3; amem[16'h003] = 16'sd4;
      bmem[16'h100] = 16'sd5; bmem[16'h101] = 16'sd6; bmem[16'h102] = 16'sd7; bmem[16'h103] = 16'sd8;
   endtask

   task automatic check_2x2(input string tag);
      logic [39:0] exp_d [4];
      logic [15:0] exp_ra [8];
      exp_d  = '{40'd19, 40'd22, 40'd43, 40'd50};
      exp_ra = '{16'h0, 16'h1, 16'h0, 16'h1, 16'h2, 16'h3, 16'h2, 16'h3};
      checks++;
      if (timed_out !== 1'b0 || done_rel !== 17) begin
         errors++; $display("FAIL %s done_cycle got %0d want 17", tag, done_rel);
      end
      checks++;
      if (wa.size() !== 4) begin errors++; $display("FAIL %s write_count got %0d want 4", tag, wa.size()); end
      for (int e = 0; e < 4 && e < wa.size(); e++) begin
         checks++;
         if (wa[e] !== 16'h200 + 16'(e) || wd[e] !== exp_d[e] || wc[e] !== (e + 1) * 4) begin
            errors++;
            $display("FAIL %s write%0d got addr %h data %0d cyc %0d want addr %h data %0d cyc %0d",
                     tag, e, wa[e], wd[e], wc[e], 16'h200 + 16'(e), exp_d[e], (e + 1) * 4);
         end
      end
      checks++;
      if (rd_cnt !== 8 || rd_bits[15:0] !== 16'h3333) begin
         errors++; $display("FAIL %s rd_pattern got %0d/%h want 8/3333", tag, rd_cnt, rd_bits[15:0]);
      end
      for (int r = 0; r < 8 && r < ra.size(); r++) begin
         checks++;
         if (ra[r] !== exp_ra[r]) begin
            errors++; $display("FAIL %s a_addr%0d got %h want %h", tag, r, ra[r], exp_ra[r]);
         end
      end
      checks++;
      if (busy1 !== 1 || busy_after !== 0) begin
         errors++; $display("FAIL %s busy got %0d/%0d want 1/0", tag, busy1, busy_after);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b1; bus.m = 8'd2; bus.k = 8'd2; bus.n = 8'd2;
      bus.a_base = '0; bus.b_base = '0; bus.c_base = '0;
      repeat (3) @(negedge clock);
      checks++;
      if (out_vec() !== 92'd0) begin
         errors++; $display("FAIL reset_outputs got %h want 0", out_vec());
      end
      bus.start = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
         errors++; $display("FAIL reset_idle got busy %b rd_en %b want 0 0", bus.busy, bus.rd_en);
      end
   endtask

   task automatic test_2x2();
      load_2x2();
      run_cmd(8'd2, 8'd2, 8'd2, 16'h000, 16'h100, 16'h200, -1, -1, 100);
      check_2x2("mm2x2");
   endtask

   task automatic test_signed_row();
      logic [39:0] exp_d [3];
      exp_d = '{40'hFFFFFFFFFA, 40'd8, 40'hFFFFFFFFF6};
      amem[16'h010] = -16'sd2;
      bmem[16'h020] = 16'sd3; bmem[16'h021] = -16'sd4; bmem[16'h022] = 16'sd5;
      run_cmd(8'd1, 8'd1, 8'd3, 16'h010, 16'h020, 16'h300, -1, -1, 100);
      checks++;
      if (done_rel !== 10 || wa.size() !== 3) begin
         errors++; $display("FAIL signed_done got cyc %0d writes %0d want 10 3", done_rel, wa.size());
      end
      for (int e = 0; e < 3 && e < wa.size(); e++) begin
         checks++;
         if (wa[e] !== 16'h300 + 16'(e) || wd[e] !== exp_d[e] || wc[e] !== (e + 1) * 3) begin
            errors++;
            $display("FAIL signed_write%0d got addr %h data %h cyc %0d want addr %h data %h cyc %0d",
                     e, wa[e], wd[e], wc[e], 16'h300 + 16'(e), exp_d[e], (e + 1) * 3);
         end
      end
   endtask

   task automatic test_zero_dim();
      run_cmd(8'd4, 8'd0, 8'd4, 16'h000, 16'h100, 16'h200, -1, -1, 20);
      checks++;
      if (done_rel !== 1 || rd_cnt !== 0 || wa.size() !== 0) begin
         errors++;
         $display("FAIL zero_dim got done %0d rd %0d wr %0d want 1 0 0", done_rel, rd_cnt, wa.size());
      end
      checks++;
      if (busy_after !== 0) begin errors++; $display("FAIL zero_busy got %0d want 0", busy_after); end
   endtask

   task automatic test_wrap_extreme();
      amem[16'hFFFF] = -16'sd32768; amem[16'h0000] = 16'sd3;
      bmem[16'h0010] = -16'sd32768;
      run_cmd(8'd2, 8'd1, 8'd1, 16'hFFFF, 16'h0010, 16'h0400, -1, -1, 100);
      checks++;
      if (ra.size() !== 2 || ra[0] !== 16'hFFFF || ra[1] !== 16'h0000) begin
         errors++; $display("FAIL wrap_addr got n=%0d %h %h want 2 ffff 0000", ra.size(), ra[0], ra[1]);
      end
      checks++;
      if (wd.size() !== 2 || wd[0] !== 40'h0040000000 || wd[1] !== 40'hFFFFFE8000) begin
         errors++; $display("FAIL wrap_data got %h %h want 0040000000 fffffe8000", wd[0], wd[1]);
      end
      checks++;
      if (done_rel !== 7) begin errors++; $display("FAIL wrap_done got %0d want 7", done_rel); end
   endtask

   task automatic test_start_ignored();
      load_2x2();
      run_cmd(8'd2, 8'd2, 8'd2, 16'h000, 16'h100, 16'h200, 5, -1, 100);
      check_2x2("start_mid");
      run_cmd(8'd2, 8'd2, 8'd2, 16'h000, 16'h100, 16'h200, 17, -1, 100);
      check_2x2("start_in_done");
      @(negedge clock);
      checks++;
      if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
         errors++; $display("FAIL start_in_done_idle got busy %b rd_en %b want 0 0", bus.busy, bus.rd_en);
      end
   endtask

   task automatic test_reset_mid_run();
      load_2x2();
      run_cmd(8'd2, 8'd2, 8'd2, 16'h000, 16'h100, 16'h200, -1, 5, 20);
      checks++;
      if (snap !== 92'd0) begin errors++; $display("FAIL reset_mid_outputs got %h want 0", snap); end
      checks++;
      if (wa.size() !== 1 || wd[0] !== 40'd19 || done_rel !== -1) begin
         errors++;
         $display("FAIL reset_mid_writes got %0d writes done %0d want 1 write of 19 and no done",
                  wa.size(), done_rel);
      end
      checks++;
      if (rd_cnt !== 3) begin errors++; $display("FAIL reset_mid_reads got %0d want 3", rd_cnt); end
      run_cmd(8'd2, 8'd2, 8'd2, 16'h000, 16'h100, 16'h200, -1, -1, 100);
      check_2x2("after_reset");
   endtask

   initial begin
      bus.start = 1'b0; bus.m = '0; bus.k = '0; bus.n = '0;
      bus.a_base = '0; bus.b_base = '0; bus.c_base = '0;
      test_reset();
      test_2x2();
      test_signed_row();
      test_zero_dim();
      test_wrap_extreme();
      test_start_ignored();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Controller that sequences a multiply-accumulate datapath to compute C = A × B for row-major integer matrices held in external synchronous RAM. It generates read addresses for A and B, accumulates signed products into a per-element accumulator and writes each finished C element back. Matrix dimensions and base addresses are loaded at start. It sits between the host command interface and the shared operand/result memories of the tensor engine.

## Interface
Parameters:
- DIM_W, 8: width of the dimension inputs m, k, n.
- ADDR_W, 16: memory address width.
- DATA_W, 16: operand width (signed two's complement).
- ACC_W, 40: accumulator and result width.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; accepted only in IDLE.
- m, k, n  in  DIM_W each  A is m×k, B is k×n, C is m×n; sampled with start.
- a_base, b_base, c_base  in  ADDR_W each  matrix base addresses; sampled with start.
- rd_en  out  1  read strobe for both operand memories.
- a_addr, b_addr  out  ADDR_W each  operand read addresses, valid while rd_en=1.
- a_data, b_data  in  DATA_W each  read data, valid exactly 1 cycle after the rd_en cycle.
- c_we  out  1  result write strobe.
- c_addr  out  ADDR_W  result address, valid while c_we=1.
- c_data  out  ACC_W  result value, valid while c_we=1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- Layout: A[i][j] at a_base+i·k+j; B[j][l] at b_base+j·n+l; C[i][l] at c_base+i·n+l. All address arithmetic is modulo 2^ADDR_W.
- Addresses are formed incrementally with row/column base accumulators. No address multipliers.
- Element order: i outer, l inner (C written at c_base, c_base+1, …, c_base+m·n−1).
- States:
  - IDLE: all outputs 0. On start, latch inputs. If m, k or n is 0, go to DONE. Otherwise go to FETCH with i=l=j=0.
  - FETCH: rd_en=1 with a_addr=A[i][j], b_addr=B[j][l]. j increments each cycle. After the cycle with j=k−1, go to DRAIN.
  - DRAIN: one cycle. Absorbs the last operand pair.
  - WRITE: one cycle. c_we=1 with c_addr=C[i][l] and c_data=accumulator. If this was the last element go to DONE. Otherwise advance (l, i) and go to FETCH with j=0.
  - DONE: done=1 for one cycle, then IDLE.
- Accumulate: the product a_data×b_data is computed signed at 2·DATA_W bits, sign-extended to ACC_W. It is added in the cycle after each rd_en cycle. The first product of each element loads the accumulator instead of adding, so no separate clear cycle is needed. Overflow wraps modulo 2^ACC_W.
- start while busy (any non-IDLE state, including DONE) is ignored. Latched parameters do not change mid-run.
- reset in any state: next cycle is IDLE. All outputs and counters are 0. No further rd_en or c_we. The partial result is discarded.

## Timing
- Reset values: rd_en, a_addr, b_addr, c_we, c_addr, c_data, busy and done are all 0. State is IDLE.
- start accepted in cycle 0 → first rd_en in cycle 1. busy goes high in cycle 1.
- Each element takes k+2 cycles: k FETCH, 1 DRAIN, 1 WRITE.
- The write of element e occurs at cycle (e+1)·(k+2).
- done is high at cycle m·n·(k+2)+1. busy is low from the following cycle.
- Zero dimension: done at cycle 1, with no rd_en and no c_we.
- Within an element, rd_en is continuous with no bubbles. Between consecutive elements rd_en is low for exactly 2 cycles.

## Test plan
- m=k=n=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], bases 0x000/0x100/0x200 → writes 19, 22, 43, 50 at 0x200–0x203 in cycles 4, 8, 12, 16; done at cycle 17.
- m=1, k=1, n=3, A=[−2], B=[3,−4,5] → C=[−6, 8, −10] sign-extended to 40 bits, writes in cycles 3, 6, 9; done at cycle 10.
- k=0 (m=n=4) → done in cycle 1, rd_en and c_we never asserted.
- m=k=n=1, a=b=−32768 → c_data=0x0040000000. Run with a_base=0xFFFF: a_addr=0xFFFF; with m=2 the next A address wraps to 0x0000.
- start pulsed mid-run with different dimensions → ignored; results and cycle counts identical to the first command.
- reset asserted in the FETCH of element 1 of the 2×2 case → next cycle all outputs are 0 and state is IDLE; no write of element 1. A fresh start afterwards reproduces the 19, 22, 43, 50 sequence.
